fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling buffer between the instruction-fetch datapath (PC register, branch/PC+4 adders) and the decode stage. It captures each fetched instruction together with its PC into a small circular FIFO and presents the oldest entry to decode through a valid/ready handshake. A branch-taken redirect flushes every buffered entry, so decode never sees wrong-path instructions.

## Interface
- DEPTH, 4, number of entries; must be a power of two, minimum 2
- clk  in  1  rising-edge clock for all state
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  fetch presents an instruction this cycle
- in_ready  out  1  queue can accept (not full)
- in_instr  in  32  fetched instruction word
- in_pc  in  64  PC of in_instr
- flush  in  1  branch taken/redirect; discard all contents
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode consumes the head entry this cycle
- out_instr  out  32  head instruction; 0 when out_valid=0
- out_pc  out  64  head PC; 0 when out_valid=0
- out_pc_plus4  out  64  out_pc + 4, mod 2^64; 0 when out_valid=0
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH registers of {instr[31:0], pc[63:0]}, write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits each, wrap from DEPTH-1 to 0), occupancy counter count.
- push = in_valid & in_ready & ~flush: entry[wr_ptr] <= {in_instr, in_pc}, wr_ptr <= wr_ptr+1.
- pop = out_valid & out_ready & ~flush: rd_ptr <= rd_ptr+1.
- count next: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
- flush (highest priority after reset): wr_ptr, rd_ptr, count <= 0 on the next edge; a coinciding push and pop are both suppressed; storage contents need not be cleared.
- in_ready = (count != DEPTH); out_valid = (count != 0). Both depend only on registered state, never combinationally on in_valid, out_ready or flush.
- Full: in_ready=0, incoming instruction is not captured; fetch must hold it. Push while full is impossible by construction, including when a pop occurs the same cycle (no full bypass).
- Empty: out_valid=0, head outputs zero; a push into an empty queue is not forwarded the same cycle (no empty bypass).
- Head outputs are a combinational read of entry[rd_ptr], gated to zero when empty.
- out_pc_plus4 uses a 64-bit adder; carry out of bit 63 discarded.
- Reset: asynchronous; wr_ptr, rd_ptr, count, and all storage go to 0 while reset=1. Outputs during/after reset: in_ready=1, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, count=0. Reset asserted mid-operation discards all entries without waiting for a clock edge.

## Timing
- Push-to-visible latency: 1 cycle (entry pushed at edge N is out_valid after edge N).
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- flush asserted in cycle N: out_valid=0 and in_ready=1 after edge N; a push in cycle N+1 is visible after edge N+1.
- All state changes on rising clk except reset, which acts immediately.

## Test plan
- Reset: assert reset asynchronously mid-cycle with 2 entries held -> immediately count=0, out_valid=0, in_ready=1, out_instr=0, out_pc=0.
- Fill/full: push instrs 32'h8B020020, 32'hCB030041, 32'hF8400062, 32'hB4000083 at PCs 0,4,8,12 with out_ready=0 -> count=4, in_ready=0; a fifth push (32'h17FFFFFD, PC 16) is ignored; head = 32'h8B020020, out_pc=0, out_pc_plus4=4.
- Drain in order: from full, out_ready=1 four cycles -> heads appear in push order with PCs 0,4,8,12; then out_valid=0, count=0, outputs 0.
- Simultaneous push/pop and wrap: keep count=2 while pushing/popping every cycle for 10 cycles (pointers wrap twice) -> count stays 2, output PC sequence strictly increases by 4, no entry lost or duplicated.
- Flush priority: count=3, assert flush together with in_valid=1 and out_ready=1 -> after edge count=0, out_valid=0, the pushed instruction is not stored; next push (PC 64'h100) emerges with out_pc=64'h100.
- PC wrap: push PC 64'hFFFFFFFFFFFFFFFC -> out_pc_plus4=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Circular FIFO between instruction fetch and decode: holds {instr, pc} pairs,
// presents the oldest to decode, and drops everything on a branch redirect.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [31:0]                in_instr_i,
   input  logic [63:0]                in_pc_i,
   input  logic                       flush_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [31:0]                out_instr_o,
   output logic [63:0]                out_pc_o,
   output logic [63:0]                out_pc_plus4_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   instr_q [DEPTH];
   logic [63:0]   pc_q    [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   // Handshake flags come only from registered occupancy, so fetch and decode
   // never see a combinational path through this block.
   assign in_ready_o  = (count_q != CW'(DEPTH));
   assign out_valid_o = (count_q != '0);

   assign push = in_valid_i & in_ready_o & ~flush_i;
   assign pop  = out_valid_o & out_ready_i & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            instr_q[gi] <= '0;
            pc_q[gi]    <= '0;
         end else if (push && (wr_ptr_q == AW'(gi))) begin
            instr_q[gi] <= in_instr_i;
            pc_q[gi]    <= in_pc_i;
         end
      end
   end

   // Head is gated to zero while empty so decode sees a clean bubble.
   assign out_instr_o    = out_valid_o ? instr_q[rd_ptr_q] : '0;
   assign out_pc_o       = out_valid_o ? pc_q[rd_ptr_q]    : '0;
   assign out_pc_plus4_o = out_valid_o ? (pc_q[rd_ptr_q] + 64'd4) : '0;
   assign count_o        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver queues expected entries as it
// issues pushes, and a monitor checks each entry decode consumes.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc, out_pc_plus4;
   logic [2:0]  count;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .reset_i(reset),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_instr_i(in_instr), .in_pc_i(in_pc),
      .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_instr_o(out_instr), .out_pc_o(out_pc),
      .out_pc_plus4_o(out_pc_plus4), .count_o(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } entry_t;

   entry_t exp_q[$];
   int     tests = 0;
   int     fails = 0;
   int     m_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every accepted pop must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("pop_underflow", 64'd1, 64'd0);
         end else begin
            entry_t e;
            e = exp_q.pop_front();
            check("pop_instr", {32'd0, out_instr}, {32'd0, e.instr});
            check("pop_pc", out_pc, e.pc);
            check("pop_pc_plus4", out_pc_plus4, e.pc + 64'd4);
            $display("[TB] pop instr=%h pc=%h", out_instr, out_pc);
         end
      end else if (!out_valid) begin
         check("empty_head_zero", {out_instr, 32'd0} | out_pc | out_pc_plus4, 64'd0);
      end
   end

   // One clock of stimulus; entered and left 1 time unit after a rising edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                       input logic rdy, input logic fl);
      logic p_push, p_pop;
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
      @(negedge clk);
      check("count", {61'd0, count}, 64'(m_count));
      check("in_ready", {63'd0, in_ready}, {63'd0, m_count != DEPTH});
      check("out_valid", {63'd0, out_valid}, {63'd0, m_count != 0});
      #1;
      p_push = v && (m_count != DEPTH) && !fl;
      p_pop  = rdy && (m_count != 0) && !fl;
      if (fl) begin
         exp_q.delete();
         m_count = 0;
      end else begin
         if (p_push) begin
            entry_t e;
            e.instr = ins;
            e.pc    = pc;
            exp_q.push_back(e);
            $display("[TB] push instr=%h pc=%h", ins, pc);
         end
         m_count = m_count + int'(p_push) - int'(p_pop);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_count", {61'd0, count}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);

      // Asynchronous reset with two entries held
      step(1'b1, 32'hAAAA0001, 64'h40, 1'b0, 1'b0);
      step(1'b1, 32'hAAAA0002, 64'h44, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("arst_count", {61'd0, count}, 64'd0);
      check("arst_out_valid", {63'd0, out_valid}, 64'd0);
      check("arst_in_ready", {63'd0, in_ready}, 64'd1);
      check("arst_out_instr", {32'd0, out_instr}, 64'd0);
      check("arst_out_pc", out_pc, 64'd0);
      exp_q.delete();
      m_count = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      $display("[TB] async reset with 2 entries held");

      // Fill to full; fifth push must be ignored
      step(1'b1, 32'h8B020020, 64'd0,  1'b0, 1'b0);
      step(1'b1, 32'hCB030041, 64'd4,  1'b0, 1'b0);
      step(1'b1, 32'hF8400062, 64'd8,  1'b0, 1'b0);
      step(1'b1, 32'hB4000083, 64'd12, 1'b0, 1'b0);
      step(1'b1, 32'h17FFFFFD, 64'd16, 1'b0, 1'b0);
      check("full_count", {61'd0, count}, 64'd4);
      check("full_in_ready", {63'd0, in_ready}, 64'd0);
      check("full_head_instr", {32'd0, out_instr}, 64'h8B020020);
      check("full_head_pc", out_pc, 64'd0);
      check("full_head_pc4", out_pc_plus4, 64'd4);

      // Drain in order
      for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      check("drain_out_valid", {63'd0, out_valid}, 64'd0);
      check("drain_count", {61'd0, count}, 64'd0);
      check("drain_out_pc", out_pc, 64'd0);
      check("drain_sb_empty", 64'(exp_q.size()), 64'd0);

      // Steady push+pop at count=2, pointers wrap twice
      step(1'b1, 32'h11110000, 64'h200, 1'b0, 1'b0);
      step(1'b1, 32'h11110001, 64'h204, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         step(1'b1, 32'h11110002 + 32'(i), 64'h208 + 64'(4 * i), 1'b1, 1'b0);
      check("wrap_count", {61'd0, count}, 64'd2);
      check("wrap_head_pc", out_pc, 64'h228);
      step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      check("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

      // Flush beats coinciding push and pop
      step(1'b1, 32'h22220000, 64'h300, 1'b0, 1'b0);
      step(1'b1, 32'h22220001, 64'h304, 1'b0, 1'b0);
      step(1'b1, 32'h22220002, 64'h308, 1'b0, 1'b0);
      step(1'b1, 32'hDEADBEEF, 64'h30C, 1'b1, 1'b1);
      check("flush_count", {61'd0, count}, 64'd0);
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      check("flush_in_ready", {63'd0, in_ready}, 64'd1);
      step(1'b1, 32'h33330000, 64'h100, 1'b0, 1'b0);
      check("post_flush_pc", out_pc, 64'h100);
      check("post_flush_instr", {32'd0, out_instr}, 64'h33330000);
      step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

      // PC + 4 wraps to zero
      step(1'b1, 32'h44440000, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0);
      check("pc_wrap_plus4", out_pc_plus4, 64'd0);
      check("pc_wrap_pc", out_pc, 64'hFFFFFFFFFFFFFFFC);
      step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
      idle();
      check("final_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
